// File: rtl/multiplier_nxm_seq_if.sv
// Operand/result bundle for the sequential NxM multiplier.
// The master drives the request and operands; the slave returns status and product.
interface multiplier_nxm_seq_if #(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 8
);
   logic                       start;
   logic                       signed_mode;
   logic [WIDTH_A-1:0]         dataa;
   logic [WIDTH_B-1:0]         datab;
   logic                       busy;
   logic                       done_flag;
   logic [WIDTH_A+WIDTH_B-1:0] product8;

   modport master (
      output start, signed_mode, dataa, datab,
      input  busy, done_flag, product8
   );

   modport slave (
      input  start, signed_mode, dataa, datab,
      output busy, done_flag, product8
   );
endinterface

// File: rtl/multiplier_nxm_seq.sv
// Sequential shift-add multiplier, WIDTH_A x WIDTH_B, signed or unsigned per operation.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multiplier_nxm_seq #(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 8
) (
   input  logic                  clk,
   input  logic                  reset_a,
   multiplier_nxm_seq_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH_B + 1);
   localparam int PW    = WIDTH_A + WIDTH_B;

   typedef enum logic {IDLE, CALC} state_t;

   state_t             state, state_nx;
   logic [WIDTH_A-1:0] mag_a, mag_a_nx;
   logic [WIDTH_B-1:0] mag_b, mag_b_nx;
   logic               neg, neg_nx;
   logic [PW-1:0]      acc, acc_nx;
   logic [CNT_W-1:0]   count, count_nx;
   logic [PW-1:0]      product, product_nx;
   logic               done, done_nx;
   logic [WIDTH_A-1:0] abs_a;
   logic [WIDTH_B-1:0] abs_b;
   logic               finish;

   // The most negative operand negates to itself, which read unsigned is its true magnitude.
   assign abs_a = (bus.signed_mode && bus.dataa[WIDTH_A-1]) ? WIDTH_A'(-bus.dataa) : bus.dataa;
   assign abs_b = (bus.signed_mode && bus.datab[WIDTH_B-1]) ? WIDTH_B'(-bus.datab) : bus.datab;

`ifdef EARLY_TERM_EN
   assign finish = (mag_b == '0);
`else
   assign finish = (count == CNT_W'(WIDTH_B));
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      mag_a_nx   = mag_a;
      mag_b_nx   = mag_b;
      neg_nx     = neg;
      acc_nx     = acc;
      count_nx   = count;
      product_nx = product;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               mag_a_nx = abs_a;
               mag_b_nx = abs_b;
               neg_nx   = bus.signed_mode & (bus.dataa[WIDTH_A-1] ^ bus.datab[WIDTH_B-1]);
               acc_nx   = '0;
               count_nx = '0;
               state_nx = CALC;
            end
         end
         CALC: begin
            if (finish) begin
               product_nx = neg ? -acc : acc;
               done_nx    = 1'b1;
               state_nx   = IDLE;
            end else begin
               if (mag_b[0]) acc_nx = acc + (PW'(mag_a) << count);
               mag_b_nx = mag_b >> 1;
               count_nx = count + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset_a) begin
         state   <= IDLE;
         mag_a   <= '0;
         mag_b   <= '0;
         neg     <= 1'b0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         mag_a   <= mag_a_nx;
         mag_b   <= mag_b_nx;
         neg     <= neg_nx;
         acc     <= acc_nx;
         count   <= count_nx;
         product <= product_nx;
         done    <= done_nx;
      end
   end

   assign bus.busy      = (state == CALC);
   assign bus.done_flag = done;
   assign bus.product8  = product;
endmodule

// File: tb/tb_multiplier_nxm_seq.sv
// Self-checking bench for multiplier_nxm_seq: 8x8 instance driven through a scoreboard,
// plus a 12x4 instance for the alternate-width case.
module tb_multiplier_nxm_seq;
   logic clk = 1'b0;
   logic reset_a;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multiplier_nxm_seq_if #(.WIDTH_A(8),  .WIDTH_B(8)) bus ();
   multiplier_nxm_seq_if #(.WIDTH_A(12), .WIDTH_B(4)) bus12 ();

   multiplier_nxm_seq #(.WIDTH_A(8),  .WIDTH_B(8)) dut   (.clk(clk), .reset_a(reset_a), .bus(bus));
   multiplier_nxm_seq #(.WIDTH_A(12), .WIDTH_B(4)) dut12 (.clk(clk), .reset_a(reset_a), .bus(bus12));

   typedef struct {
      logic [15:0] prod;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   acc_cyc  = 0;
   int   done_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input bit sm);
      logic signed [15:0] xa, xb;
      if (sm) begin
         xa = {{8{a[7]}}, a};
         xb = {{8{b[7]}}, b};
         return 16'(xa * xb);
      end
      return {8'h00, a} * {8'h00, b};
   endfunction

   function automatic int exp_lat(input logic [7:0] b, input bit sm);
`ifdef EARLY_TERM_EN
      logic [7:0] m;
      int l;
      m = (sm && b[7]) ? 8'(-b) : b;
      l = 1;
      for (int i = 0; i < 8; i++) if (m[i]) l = i + 2;
      return l;
`else
      return 9;
`endif
   endfunction

   // Drive one request on an idle DUT and queue its expected outcome.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit sm, input string tag);
      exp_t e;
      @(negedge clk);
      bus.dataa = a; bus.datab = b; bus.signed_mode = sm; bus.start = 1'b1;
      e.prod = model(a, b, sm); e.lat = exp_lat(b, sm); e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
      acc_cyc = cyc;
      check({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
   endtask

   // Wait (bounded) for done_flag, then pop and compare against the scoreboard.
   task automatic wait_result(input bit inject, input bit post_idle);
      logic [15:0] old_prod;
      bit          seen, held_ok;
      int          busy_cyc, lat;
      exp_t        e;
      old_prod = bus.product8; seen = 1'b0; held_ok = 1'b1; busy_cyc = 1; lat = 0;
      for (int i = 1; i <= 30; i++) begin
         if (inject && (i == 3 || i == 8)) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.dataa = 8'($urandom); bus.datab = 8'($urandom); bus.signed_mode = 1'($urandom);
         end
         @(posedge clk); #1;
         if (inject) bus.start = 1'b0;
         if (bus.done_flag) begin
            seen = 1'b1; lat = cyc - acc_cyc; done_cyc = cyc;
            break;
         end
         if (bus.busy) busy_cyc++;
         if (bus.product8 !== old_prod) held_ok = 1'b0;
      end
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      if (!seen) begin
         check({e.tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({e.tag, "_prod"}, 32'(bus.product8), 32'(e.prod));
      check({e.tag, "_lat"}, lat, e.lat);
      check({e.tag, "_busy_cycles"}, busy_cyc, e.lat);
      check({e.tag, "_prod_held"}, 32'(held_ok), 32'd1);
      check({e.tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      if (post_idle) begin
         int extra_done = 0;
         bit busy_seen = 1'b0;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done_flag) extra_done++;
            if (bus.busy) busy_seen = 1'b1;
         end
         check({e.tag, "_single_done"}, extra_done, 0);
         check({e.tag, "_idle_after"}, 32'(busy_seen), 32'd0);
         check({e.tag, "_prod_kept"}, 32'(bus.product8), 32'(e.prod));
      end
   endtask

   initial begin
      int n_done;
      exp_t e;
      reset_a = 1'b1;
      bus.start = 1'b0; bus.signed_mode = 1'b0; bus.dataa = '0; bus.datab = '0;
      bus12.start = 1'b0; bus12.signed_mode = 1'b0; bus12.dataa = '0; bus12.datab = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done_flag), 32'd0);
      check("rst_prod", 32'(bus.product8), 32'd0);
      @(negedge clk) reset_a = 1'b0;

      // Unsigned maximum, then a small product that must not disturb the held result early.
      launch(8'd255, 8'd255, 1'b0, "u255x255");
      wait_result(1'b0, 1'b1);
      check("u255x255_hex", 32'(bus.product8), 32'h0000_FE01);
      launch(8'd10, 8'd30, 1'b0, "u10x30");
      wait_result(1'b0, 1'b1);

      // Signed corners.
      launch(8'h80, 8'h80, 1'b1, "s_min_min");
      wait_result(1'b0, 1'b1);
      check("s_min_min_hex", 32'(bus.product8), 32'h0000_4000);
      launch(8'hFF, 8'h7F, 1'b1, "s_m1_x127");
      wait_result(1'b0, 1'b1);
      launch(8'h05, 8'h00, 1'b1, "s_5x0");
      wait_result(1'b0, 1'b1);
      launch(8'h00, 8'h01, 1'b0, "u_0x1");
      wait_result(1'b0, 1'b1);
      launch(8'h81, 8'h01, 1'b1, "s_m127x1");
      wait_result(1'b0, 1'b1);

      // Starts during an operation are ignored.
      launch(8'd7, 8'd6, 1'b0, "ign_7x6");
      wait_result(1'b1, 1'b1);

      // A few random operations.
      for (int i = 0; i < 6; i++) begin
         launch(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
         wait_result(1'b0, 1'b1);
      end

      // Reset in the middle of an operation discards it.
      launch(8'd7, 8'd6, 1'b0, "aborted");
      repeat (3) @(posedge clk);
      @(negedge clk) reset_a = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done_flag), 32'd0);
      check("midrst_prod", 32'(bus.product8), 32'd0);
      @(negedge clk) reset_a = 1'b0;
      sb_q.delete();
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.done_flag) n_done++;
      end
      check("midrst_no_done", n_done, 0);
      launch(8'd3, 8'd3, 1'b0, "after_rst_3x3");
      wait_result(1'b0, 1'b1);

      // start held high: second op accepted one cycle after done_flag; post-accept operand changes ignored.
      @(negedge clk);
      bus.dataa = 8'd2; bus.datab = 8'd3; bus.signed_mode = 1'b0; bus.start = 1'b1;
      e.prod = 16'd6; e.lat = exp_lat(8'd3, 1'b0); e.tag = "b2b_first";
      sb_q.push_back(e);
      @(posedge clk); #1;
      acc_cyc = cyc;
      bus.dataa = 8'd4; bus.datab = 8'd5;
      wait_result(1'b0, 1'b0);
      e.prod = 16'd20; e.lat = exp_lat(8'd5, 1'b0); e.tag = "b2b_second";
      sb_q.push_back(e);
      @(posedge clk); #1;
      acc_cyc = cyc;
      bus.start = 1'b0;
      check("b2b_gap", acc_cyc - done_cyc, 1);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_result(1'b0, 1'b1);

      // Alternate widths: 12x4 unsigned.
      begin
         int c0, lat12;
         bit seen12;
         @(negedge clk);
         bus12.dataa = 12'd4095; bus12.datab = 4'd15; bus12.signed_mode = 1'b0; bus12.start = 1'b1;
         @(posedge clk); #1;
         bus12.start = 1'b0;
         c0 = cyc; seen12 = 1'b0; lat12 = 0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus12.done_flag) begin
               seen12 = 1'b1; lat12 = cyc - c0;
               break;
            end
         end
         check("w12x4_seen", 32'(seen12), 32'd1);
         check("w12x4_prod", 32'(bus12.product8), 32'h0000_EFF1);
         check("w12x4_lat", lat12, 5);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
